// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first.
// Operands are captured on an accepted start. The sum/carry are published
// together with a one-cycle done pulse once all WIDTH bits have been added.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;
  logic             carry;
  logic [CW-1:0]    count;
  logic             s;
  logic             c_nx;
  logic             last;

  // Full-adder cell on the current LSBs, plus the result shift with s entering at the MSB
  always_comb begin
    s      = a_sh[0] ^ b_sh[0] ^ carry;
    c_nx   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    res_nx = res >> 1;
    res_nx[WIDTH-1] = s;
    last   = (count == CW'(WIDTH - 1));
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Registered status flags, derived from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx == RUN);
      done <= (state_nx == DONE);
    end
  end

  // Operand shifters, carry flop, bit counter and result publication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
            res   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= c_nx;
          res   <= res_nx;
          count <= count + 1'b1;
          if (last) begin
            sum  <= res_nx;
            cout <= c_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH = 8, 3 and 1.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst8 = 1'b0, rst3 = 1'b0, rst1 = 1'b0;
  logic       st8 = 1'b0, st3 = 1'b0, st1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [2:0] a3 = '0, b3 = '0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ci8 = 1'b0, ci3 = 1'b0, ci1 = 1'b0;
  logic       busy8, busy3, busy1;
  logic       done8, done3, done1;
  logic [7:0] sum8;
  logic [2:0] sum3;
  logic [0:0] sum1;
  logic       co8, co3, co1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(st8), .a(a8), .b(b8), .cin(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(co8));

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst3), .start(st3), .a(a3), .b(b3), .cin(ci3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(co3));

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .start(st1), .a(a1), .b(b1), .cin(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(co1));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic st);
    case (id)
      0: begin a8 = a[7:0]; b8 = b[7:0]; ci8 = c; st8 = st; end
      1: begin a3 = a[2:0]; b3 = b[2:0]; ci3 = c; st3 = st; end
      default: begin a1 = a[0:0]; b1 = b[0:0]; ci1 = c; st1 = st; end
    endcase
  endtask

  function automatic logic get_busy(input int id);
    return (id == 0) ? busy8 : (id == 1) ? busy3 : busy1;
  endfunction

  function automatic logic get_done(input int id);
    return (id == 0) ? done8 : (id == 1) ? done3 : done1;
  endfunction

  function automatic logic get_cout(input int id);
    return (id == 0) ? co8 : (id == 1) ? co3 : co1;
  endfunction

  function automatic logic [31:0] get_sum(input int id);
    return (id == 0) ? 32'(sum8) : (id == 1) ? 32'(sum3) : 32'(sum1);
  endfunction

  // Reference: plain (w+1)-bit addition of the masked operands and carry-in
  function automatic longint model(input int w, input logic [31:0] a,
                                   input logic [31:0] b, input logic c);
    longint mask;
    mask = (longint'(1) << w) - 1;
    return (longint'(a) & mask) + (longint'(b) & mask) + longint'(c);
  endfunction

  function automatic longint observed(input int id, input int w);
    return longint'(get_sum(id)) | (longint'(get_cout(id)) << w);
  endfunction

  // One full transaction: start pulse, latency/flag checks, result check
  task automatic do_op(input int id, input int w, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input string tag);
    int nb;
    bit got, ovl;
    longint exp;
    exp = model(w, a, b, c);
    @(negedge clk);
    set_in(id, a, b, c, 1'b1);
    @(posedge clk); #1;
    // scramble operands after acceptance: they must not matter
    set_in(id, $urandom, $urandom, 1'($urandom), 1'b0);
    nb = 0; got = 0; ovl = 0;
    for (int k = 0; k < 80 && !got; k++) begin
      if (get_busy(id) && get_done(id)) ovl = 1;
      if (get_done(id)) got = 1;
      else begin
        if (get_busy(id)) nb++;
        @(posedge clk); #1;
      end
    end
    chk({tag, " done_seen"}, longint'(got), 1);
    chk({tag, " busy_cycles"}, nb, w);
    chk({tag, " busy_done_overlap"}, longint'(ovl), 0);
    chk({tag, " result"}, observed(id, w), exp);
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, longint'(get_done(id)), 0);
  endtask

  vec_t       tbl[4];
  logic [7:0] ha[32], hb[32];
  logic       hc[32];
  bit         dexp[32];
  int         ndone, nfree;
  bit         saw;

  initial begin
    tbl[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, cout: 1'b0};
    tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    tbl[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    tbl[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};

    // Reset state
    #1 rst8 = 1'b1; rst3 = 1'b1; rst1 = 1'b1;
    #2;
    chk("rst busy8", busy8, 0);
    chk("rst done8", done8, 0);
    chk("rst sum8", sum8, 0);
    chk("rst cout8", co8, 0);
    chk("rst busy3", busy3, 0);
    chk("rst done1", done1, 0);
    @(negedge clk); @(negedge clk);
    rst8 = 1'b0; rst3 = 1'b0; rst1 = 1'b0;

    // Directed vectors against hand-computed results
    for (int i = 0; i < 4; i++) begin
      do_op(0, 8, 32'(tbl[i].a), 32'(tbl[i].b), tbl[i].cin, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d sum_tbl", i), sum8, tbl[i].sum);
      chk($sformatf("vec%0d cout_tbl", i), co8, tbl[i].cout);
    end

    // Reset during bit 4 of 0xAA+0x55: everything clears, no done follows
    @(negedge clk);
    set_in(0, 32'hAA, 32'h55, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_in(0, 32'hAA, 32'h55, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst8 = 1'b1;
    #1;
    chk("midrun busy", busy8, 0);
    chk("midrun done", done8, 0);
    chk("midrun sum", sum8, 0);
    chk("midrun cout", co8, 0);
    #2 rst8 = 1'b0;
    saw = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done8 || busy8) saw = 1;
    end
    chk("post_reset no_activity", longint'(saw), 0);
    do_op(0, 8, 32'hAA, 32'h55, 1'b1, "aa55c1");
    chk("aa55c1 sum", sum8, 8'h00);
    chk("aa55c1 cout", co8, 1'b1);

    // Start held high with operands changing every cycle
    nfree = 0;
    foreach (dexp[k]) dexp[k] = 0;
    for (int k = 0; k < 32; k++) begin
      if (k <= 20 && k >= nfree) begin
        if (k + 8 < 32) dexp[k + 8] = 1;
        nfree = k + 10;
      end
    end
    ndone = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      ha[k] = 8'($urandom); hb[k] = 8'($urandom); hc[k] = 1'($urandom);
      set_in(0, 32'(ha[k]), 32'(hb[k]), hc[k], k <= 20);
      @(posedge clk); #1;
      chk($sformatf("hold done@%0d", k), done8, dexp[k]);
      if (done8) begin
        ndone++;
        if (k >= 8)
          chk($sformatf("hold result@%0d", k), observed(0, 8),
              model(8, 32'(ha[k-8]), 32'(hb[k-8]), hc[k-8]));
      end
    end
    chk("hold done_count", ndone, 3);

    // Random WIDTH=8 operations
    for (int i = 0; i < 30; i++)
      do_op(0, 8, $urandom, $urandom, 1'($urandom), $sformatf("rnd%0d", i));

    // WIDTH=3 exhaustive
    for (int i = 0; i < 128; i++)
      do_op(1, 3, 32'(i & 7), 32'((i >> 3) & 7), 1'((i >> 6) & 1), $sformatf("w3_%0d", i));

    // WIDTH=1: all cases, with 1+1+1 checked explicitly too
    for (int i = 0; i < 8; i++)
      do_op(2, 1, 32'(i & 1), 32'((i >> 1) & 1), 1'((i >> 2) & 1), $sformatf("w1_%0d", i));
    chk("w1 111 sum", sum1, 1'b1);
    chk("w1 111 cout", co1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
